// File: rtl/wash_phase_timer.sv
// Wash/rinse/spin phase timer with fill-valve watchdog and sticky fault for the washer FSM.
// Optional macro WASH_PAUSE_EN: pause freezes prescaler, phase count and fill watchdog.
module wash_phase_timer #(
    parameter int TICK_DIV     = 1000,
    parameter int CNT_W        = 16,
    parameter int QUICK_TICKS  = 30,
    parameter int NORMAL_TICKS = 60,
    parameter int HEAVY_TICKS  = 90,
    parameter int SPIN_TICKS   = 20,
    parameter int FILL_LIMIT   = 50
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       program_sel,
    input  logic             door_lock,
    input  logic             motor_on,
    input  logic             fill_valve_on,
    input  logic             spin_active,
    input  logic             pause,
    output logic             cycle_timeout,
    output logic             spin_timeout,
    output logic             fault,
    output logic [1:0]       active_prog,
    output logic [CNT_W-1:0] ticks_left
);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [2:0] {IDLE, WASH_T, RINSE_T, SPIN_T, FAULT} state_t;

    state_t           state;
    logic             motor_q, door_q, spin_q, fill_q;
    logic             motor_rise, door_rise, spin_rise, fill_rise;
    logic [PW-1:0]    presc, fill_presc;
    logic [CNT_W-1:0] fill_cnt;
    logic [1:0]       episode, ep_eff, sel_prog;
    logic [CNT_W-1:0] prog_ticks, half_ticks, rinse_ticks;
    logic             hold, tick_wrap, fill_trip;

`ifdef WASH_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0 & pause;
`endif

    assign motor_rise = motor_on & ~motor_q;
    assign door_rise  = door_lock & ~door_q;
    assign spin_rise  = spin_active & ~spin_q;
    assign fill_rise  = fill_valve_on & ~fill_q;
    assign tick_wrap  = (presc == PRE_LAST);
    assign fill_trip  = fill_valve_on && !fill_rise && !hold && (fill_presc == PRE_LAST)
                        && (fill_cnt == CNT_W'(FILL_LIMIT - 1));

    // A motor rise on the same edge as the door lock must see the freshly latched program.
    always_comb begin
        sel_prog = door_rise ? program_sel : active_prog;
        ep_eff   = door_rise ? 2'd0 : episode;
        case (sel_prog)
            2'b00:   prog_ticks = CNT_W'(QUICK_TICKS);
            2'b10:   prog_ticks = CNT_W'(HEAVY_TICKS);
            default: prog_ticks = CNT_W'(NORMAL_TICKS);
        endcase
        half_ticks  = prog_ticks >> 1;
        rinse_ticks = (half_ticks == '0) ? CNT_W'(1) : half_ticks;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            motor_q       <= 1'b0;
            door_q        <= 1'b0;
            spin_q        <= 1'b0;
            fill_q        <= 1'b0;
            presc         <= '0;
            fill_presc    <= '0;
            fill_cnt      <= '0;
            episode       <= 2'd0;
            cycle_timeout <= 1'b0;
            spin_timeout  <= 1'b0;
            fault         <= 1'b0;
            active_prog   <= 2'b00;
            ticks_left    <= '0;
        end else begin
            motor_q       <= motor_on;
            door_q        <= door_lock;
            spin_q        <= spin_active;
            fill_q        <= fill_valve_on;
            cycle_timeout <= 1'b0;
            spin_timeout  <= 1'b0;

            if (door_rise) begin
                active_prog <= program_sel;
                episode     <= 2'd0;
            end

            if (state != FAULT) begin
                if (!fill_valve_on) begin
                    fill_presc <= '0;
                    fill_cnt   <= '0;
                end else if (fill_rise) begin
                    fill_presc <= PW'(1);
                end else if (!hold) begin
                    if (fill_presc == PRE_LAST) begin
                        fill_presc <= '0;
                        fill_cnt   <= fill_cnt + CNT_W'(1);
                    end else begin
                        fill_presc <= fill_presc + PW'(1);
                    end
                end
            end

            if (state == FAULT) begin
                if (!door_lock) begin
                    state      <= IDLE;
                    fault      <= 1'b0;
                    fill_presc <= '0;
                    fill_cnt   <= '0;
                end
            end else if (fill_trip) begin
                state      <= FAULT;
                fault      <= 1'b1;
                ticks_left <= '0;
                presc      <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (motor_rise && ep_eff == 2'd0) begin
                            state      <= WASH_T;
                            ticks_left <= prog_ticks;
                            presc      <= '0;
                            episode    <= 2'd1;
                        end else if (motor_rise && ep_eff == 2'd1) begin
                            state      <= RINSE_T;
                            ticks_left <= rinse_ticks;
                            presc      <= '0;
                            episode    <= 2'd2;
                        end else if (spin_rise) begin
                            state      <= SPIN_T;
                            ticks_left <= CNT_W'(SPIN_TICKS);
                            presc      <= '0;
                        end
                    end
                    WASH_T, RINSE_T, SPIN_T: begin
                        // Aborts are checked before expiry so an abort on the expiry edge wins.
                        if (!door_lock || (state == SPIN_T ? !spin_active : !motor_on)) begin
                            state      <= IDLE;
                            ticks_left <= '0;
                            presc      <= '0;
                        end else if (!hold) begin
                            if (tick_wrap) begin
                                presc <= '0;
                                if (ticks_left <= CNT_W'(1)) begin
                                    state      <= IDLE;
                                    ticks_left <= '0;
                                    if (state == SPIN_T) spin_timeout  <= 1'b1;
                                    else                 cycle_timeout <= 1'b1;
                                end else begin
                                    ticks_left <= ticks_left - CNT_W'(1);
                                end
                            end else begin
                                presc <= presc + PW'(1);
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_wash_phase_timer.sv
// Scoreboard bench for wash_phase_timer: expected pulses are queued when a phase is started.
module tb_wash_phase_timer;
    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  program_sel;
    logic        door_lock, motor_on, fill_valve_on, spin_active, pause;
    logic        cycle_timeout, spin_timeout, fault;
    logic [1:0]  active_prog;
    logic [15:0] ticks_left;

    typedef struct {int kind; int cyc;} exp_t;
    exp_t exp_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    wash_phase_timer #(
        .TICK_DIV(4), .CNT_W(16), .QUICK_TICKS(2), .NORMAL_TICKS(3),
        .HEAVY_TICKS(5), .SPIN_TICKS(2), .FILL_LIMIT(5)
    ) dut (
        .clk(clk), .reset(reset), .program_sel(program_sel), .door_lock(door_lock),
        .motor_on(motor_on), .fill_valve_on(fill_valve_on), .spin_active(spin_active),
        .pause(pause), .cycle_timeout(cycle_timeout), .spin_timeout(spin_timeout),
        .fault(fault), .active_prog(active_prog), .ticks_left(ticks_left)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // kind 0 = cycle_timeout, 1 = spin_timeout; delay counted from the load edge
    task automatic expect_pulse(input int kind, input int delay);
        exp_t e;
        e.kind = kind;
        e.cyc  = cyc + 1 + delay;
        exp_q.push_back(e);
    endtask

    task automatic lock_door(input logic [1:0] p);
        door_lock = 1'b0;
        step(2);
        program_sel = p;
        door_lock = 1'b1;
        step(1);
    endtask

    always @(negedge clk) begin
        if (cycle_timeout || spin_timeout) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("pulse_both", int'(cycle_timeout && spin_timeout), 0);
                chk("pulse_kind", spin_timeout ? 1 : 0, e.kind);
                chk("pulse_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        reset = 1'b1; program_sel = 2'b00; door_lock = 1'b0; motor_on = 1'b0;
        fill_valve_on = 1'b0; spin_active = 1'b0; pause = 1'b0;
        step(2);
        chk("rst_cycle_timeout", cycle_timeout, 0);
        chk("rst_spin_timeout", spin_timeout, 0);
        chk("rst_fault", fault, 0);
        chk("rst_active_prog", active_prog, 0);
        chk("rst_ticks_left", ticks_left, 0);
        reset = 1'b0;
        step(1);

        // normal wash, later program_sel change ignored
        lock_door(2'b01);
        chk("latch_prog", active_prog, 1);
        program_sel = 2'b10;
        motor_on = 1'b1;
        expect_pulse(0, 12);
        for (int k = 0; k < 12; k++) begin
            step(1);
            chk("wash_ticks", ticks_left, 3 - k / 4);
        end
        step(1);
        chk("wash_done_ticks", ticks_left, 0);
        chk("prog_held", active_prog, 1);

        // rinse: 3>>1 = 1 tick
        motor_on = 1'b0; step(2); motor_on = 1'b1;
        expect_pulse(0, 4);
        step(1);
        chk("rinse_ticks", ticks_left, 1);
        step(6);

        // third motor rise in the same run is ignored
        motor_on = 1'b0; step(2); motor_on = 1'b1;
        step(1);
        chk("third_ignored", ticks_left, 0);
        step(14);
        motor_on = 1'b0;

        // spin
        spin_active = 1'b1;
        expect_pulse(1, 8);
        step(1);
        chk("spin_ticks", ticks_left, 2);
        step(10);
        spin_active = 1'b0;
        step(2);

        // early abort: motor drops at T+7
        lock_door(2'b01);
        motor_on = 1'b1;
        step(7);
        chk("pre_abort_ticks", ticks_left, 2);
        motor_on = 1'b0;
        step(1);
        chk("abort_ticks", ticks_left, 0);
        step(12);

        // quick program and its rinse
        lock_door(2'b00);
        motor_on = 1'b1; expect_pulse(0, 8); step(10);
        motor_on = 1'b0; step(2);
        motor_on = 1'b1; expect_pulse(0, 4); step(6);
        motor_on = 1'b0;

        // heavy program and its rinse
        lock_door(2'b10);
        motor_on = 1'b1; expect_pulse(0, 20); step(22);
        motor_on = 1'b0; step(2);
        motor_on = 1'b1; expect_pulse(0, 8); step(10);
        motor_on = 1'b0;

        // reserved program 11 times as normal
        lock_door(2'b11);
        chk("reserved_prog", active_prog, 3);
        motor_on = 1'b1; expect_pulse(0, 12); step(14);
        motor_on = 1'b0;

        // door opens during spin
        spin_active = 1'b1;
        step(4);
        door_lock = 1'b0;
        step(1);
        chk("door_abort_ticks", ticks_left, 0);
        step(10);
        spin_active = 1'b0;

        // pause for 6 cycles during wash
        lock_door(2'b01);
        motor_on = 1'b1;
`ifdef WASH_PAUSE_EN
        expect_pulse(0, 18);
`else
        expect_pulse(0, 12);
`endif
        step(4);
        pause = 1'b1; step(6); pause = 1'b0;
        step(10);
        motor_on = 1'b0;

        // fill watchdog: interrupted fill does not trip, continuous fill does at 20
        lock_door(2'b01);
        fill_valve_on = 1'b1; step(14);
        fill_valve_on = 1'b0; step(1);
        fill_valve_on = 1'b1; step(19);
        chk("fill_no_fault", fault, 0);
        step(1);
        chk("fill_fault", fault, 1);
        chk("fault_ticks", ticks_left, 0);
        motor_on = 1'b1; step(16);
        chk("fault_no_run", ticks_left, 0);
        fill_valve_on = 1'b0; motor_on = 1'b0; step(2);
        chk("fault_sticky", fault, 1);
        door_lock = 1'b0; step(1);
        chk("fault_cleared", fault, 0);

        // reset in the middle of a wash
        lock_door(2'b01);
        motor_on = 1'b1;
        step(5);
        chk("pre_reset_ticks", ticks_left, 2);
        reset = 1'b1; motor_on = 1'b0; door_lock = 1'b0;
        #1;
        chk("mid_rst_ticks", ticks_left, 0);
        chk("mid_rst_prog", active_prog, 0);
        chk("mid_rst_fault", fault, 0);
        chk("mid_rst_cycle_timeout", cycle_timeout, 0);
        step(1);
        reset = 1'b0;
        step(16);

        step(4);
        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
